// File: rtl/cmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmul_pkg
// Purpose  : Shared definitions for the complexm result combiner. Holds the
//            default widths, the twiddle scaling shift, the saturation limits
//            of the regfft word and the sequencer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmul_pkg;

  // Width of each complexm partial product (2's complement).
  localparam int CMUL_PROD_W = 39;
  // Width of the re/im result words (regfft word width).
  localparam int CMUL_OUT_W  = 31;
  // Fractional bits of the Q1.7 twiddle factor.
  localparam int CMUL_SHIFT  = 7;

  // Saturation limits of a signed CMUL_OUT_W-bit word.
  localparam longint SAT_MAX = (longint'(1) <<< (CMUL_OUT_W - 1)) - longint'(1);
  localparam longint SAT_MIN = -(longint'(1) <<< (CMUL_OUT_W - 1));

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SUM   = 3'd3,
    ROUND = 3'd4,
    OUT   = 3'd5
  } cmul_state_t;

endpackage
`default_nettype wire

// File: rtl/cmul_combine_if.sv
`default_nettype none
// ============================================================================
// Module   : cmul_combine_if
// Purpose  : Bundles the combiner's request, complexm and result signals.
//            master : the combiner (cmul_combine)
//            slave  : the environment (requester, complexm and regfft side)
// Ports    : start/busy     - request handshake
//            mul_en, p_*    - complexm enable and partial products
//            out_*, sat_*   - result words, clip flags, valid/ready
// Revision : 1.0 - initial release
// ============================================================================
interface cmul_combine_if #(
  parameter int PROD_W = cmul_pkg::CMUL_PROD_W,
  parameter int OUT_W  = cmul_pkg::CMUL_OUT_W
);

  logic                     start;
  logic                     busy;
  logic                     mul_en;
  logic signed [PROD_W-1:0] p_ac;
  logic signed [PROD_W-1:0] p_bd;
  logic signed [PROD_W-1:0] p_bc;
  logic signed [PROD_W-1:0] p_ad;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic                     sat_re;
  logic                     sat_im;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  start,
    output busy,
    output mul_en,
    input  p_ac,
    input  p_bd,
    input  p_bc,
    input  p_ad,
    output out_re,
    output out_im,
    output sat_re,
    output sat_im,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output start,
    input  busy,
    input  mul_en,
    output p_ac,
    output p_bd,
    output p_bc,
    output p_ad,
    input  out_re,
    input  out_im,
    input  sat_re,
    input  sat_im,
    input  out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/cmul_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : cmul_round_sat
// Purpose  : Combinational scale-and-clip of one combined component.
//            res = sat((sum + 2^(SHIFT-1)) >>> SHIFT), round half toward +inf.
// Ports    : sum - (PROD_W+1)-bit signed combined partial products
//            res - OUT_W-bit signed result
//            sat - result was clipped to the OUT_W range
// Revision : 1.0 - initial release
// ============================================================================
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int PROD_W = CMUL_PROD_W,
  parameter int OUT_W  = CMUL_OUT_W,
  parameter int SHIFT  = CMUL_SHIFT
) (
  input  logic signed [PROD_W:0]  sum,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  // One guard bit above the sum: adding the rounding bias to the largest
  // positive sum must not wrap.
  localparam int EXT_W = PROD_W + 2;

  localparam logic signed [EXT_W-1:0] BIAS =
    EXT_W'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [PROD_W:0]  LIM_HI =
    (PROD_W + 1)'((longint'(1) <<< (OUT_W - 1)) - longint'(1));
  localparam logic signed [PROD_W:0]  LIM_LO =
    (PROD_W + 1)'(-(longint'(1) <<< (OUT_W - 1)));

  logic signed [EXT_W-1:0] biased;
  logic signed [PROD_W:0]  rounded;

  assign biased  = $signed({sum[PROD_W], sum}) + BIAS;
  // The shift frees SHIFT sign bits at the top, so narrowing back to
  // PROD_W+1 bits never loses information.
  assign rounded = (PROD_W + 1)'(biased >>> SHIFT);

  always_comb begin
    res = rounded[OUT_W-1:0];
    sat = 1'b0;
    if (rounded > LIM_HI) begin
      res = LIM_HI[OUT_W-1:0];
      sat = 1'b1;
    end else if (rounded < LIM_LO) begin
      res = LIM_LO[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmul_combine.sv
`default_nettype none
// ============================================================================
// Module   : cmul_combine
// Purpose  : Consumer-side sequencer for the complexm partial-product
//            multiplier. On start it pulses complexm's en, collects the four
//            partial products at the fixed complexm latency, forms
//            re = ac - bd and im = bc + ad, rescales by the Q1.7 twiddle with
//            round-half-up, saturates to the regfft word and hands the result
//            over on a valid/ready port.
// Ports    : clk   - clock
//            reset - asynchronous active-low reset
//            bus   - cmul_combine_if master: start/busy, mul_en, p_ac/p_bd/
//                    p_bc/p_ad, out_re/out_im, sat_re/sat_im,
//                    out_valid/out_ready
// Revision : 1.0 - initial release
// ============================================================================
module cmul_combine
  import cmul_pkg::*;
#(
  parameter int PROD_W = CMUL_PROD_W,
  parameter int OUT_W  = CMUL_OUT_W,
  parameter int SHIFT  = CMUL_SHIFT
) (
  input  logic           clk,
  input  logic           reset,
  cmul_combine_if.master bus
);

  cmul_state_t state;
  cmul_state_t state_nxt;

  logic                    mul_en_c;
  logic                    busy_c;
  logic                    valid_c;

  logic signed [PROD_W:0]  sre;
  logic signed [PROD_W:0]  sim;

  logic signed [OUT_W-1:0] rnd_re;
  logic signed [OUT_W-1:0] rnd_im;
  logic                    clip_re;
  logic                    clip_im;

  logic signed [OUT_W-1:0] re_q;
  logic signed [OUT_W-1:0] im_q;
  logic                    sat_re_q;
  logic                    sat_im_q;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // complexm latches its products at the end of ISSUE and presents them after
  // its own second cycle, hence the WAIT state before SUM. ISSUE is only ever
  // entered from IDLE or OUT, both of which complexm sees as its idle state,
  // so an en pulse can never land while complexm is busy.
  always_comb begin
    state_nxt = state;
    mul_en_c  = 1'b0;
    busy_c    = 1'b1;
    valid_c   = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_en_c  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = SUM;
      end
      SUM: begin
        state_nxt = ROUND;
      end
      ROUND: begin
        state_nxt = OUT;
      end
      OUT: begin
        valid_c = 1'b1;
        // A pending start goes straight back to ISSUE so back-to-back
        // requests see no idle bubble.
        if (bus.out_ready) begin
          state_nxt = bus.start ? ISSUE : IDLE;
        end
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Combine: products are sign-extended by one bit so ac - bd and bc + ad
  // cannot overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sre <= '0;
      sim <= '0;
    end else if (state == SUM) begin
      sre <= {bus.p_ac[PROD_W-1], bus.p_ac} - {bus.p_bd[PROD_W-1], bus.p_bd};
      sim <= {bus.p_bc[PROD_W-1], bus.p_bc} + {bus.p_ad[PROD_W-1], bus.p_ad};
    end
  end

  // --------------------------------------------------------------------------
  // Scale and clip, one instance per component
  // --------------------------------------------------------------------------
  cmul_round_sat #(
    .PROD_W (PROD_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_round_re (
    .sum (sre),
    .res (rnd_re),
    .sat (clip_re)
  );

  cmul_round_sat #(
    .PROD_W (PROD_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_round_im (
    .sum (sim),
    .res (rnd_im),
    .sat (clip_im)
  );

  // Result words change only on the ROUND load, so they stay stable for the
  // whole OUT phase and keep their value after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_q     <= '0;
      im_q     <= '0;
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
    end else if (state == ROUND) begin
      re_q     <= rnd_re;
      im_q     <= rnd_im;
      sat_re_q <= clip_re;
      sat_im_q <= clip_im;
    end
  end

  assign bus.mul_en    = mul_en_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = valid_c;
  assign bus.out_re    = re_q;
  assign bus.out_im    = im_q;
  assign bus.sat_re    = sat_re_q;
  assign bus.sat_im    = sat_im_q;

endmodule
`default_nettype wire
